// File: rtl/imm_gen_arbiter.sv
// imm_gen_arbiter: one shared immediate generator serving NUM_REQ requesters.
// A round-robin, work-conserving arbiter picks one valid request per cycle.
// Its immediate is captured in a single output register and returned with
// the requester id, giving one result per cycle at 1-cycle latency.
// Optional build macro IMM_GEN_ARBITER_STATS_EN adds io_grant_cnt, a set of
// saturating 16-bit per-requester grant counters.
//
// Handshake: a request transfers on a cycle where io_req_valid[k] and
// io_req_ready[k] are both 1; a result leaves on a cycle where io_resp_valid
// and io_resp_ready are both 1. Ready never depends on the same port's valid
// beyond the arbitration choice, and a held result stays stable until taken.
module imm_gen_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_flush,
  input  logic [NUM_REQ-1:0]     io_req_valid,
  output logic [NUM_REQ-1:0]     io_req_ready,
  input  logic [32*NUM_REQ-1:0]  io_req_inst,
  input  logic [3*NUM_REQ-1:0]   io_req_immSrc,
  input  logic [NUM_REQ-1:0]     io_req_immSign,
  output logic                   io_resp_valid,
  input  logic                   io_resp_ready,
  output logic [ID_W-1:0]        io_resp_id,
  output logic [31:0]            io_resp_imm
`ifdef IMM_GEN_ARBITER_STATS_EN
  ,
  output logic [16*NUM_REQ-1:0]  io_grant_cnt
`endif
);

  // RISC-V immediate decode; formats 6 and 7 fall back to the I format.
  function automatic logic [31:0] immGen(input logic [31:0] inst,
                                         input logic [2:0]  src,
                                         input logic        sign);
    logic ext;
    ext = sign & inst[31];
    case (src)
      3'd1:    immGen = {{20{ext}}, inst[31:25], inst[11:7]};
      3'd2:    immGen = {{19{ext}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      3'd3:    immGen = {inst[31:12], 12'h000};
      3'd4:    immGen = {{11{ext}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      3'd5:    immGen = {27'd0, inst[19:15]};
      default: immGen = {{20{ext}}, inst[31:20]};
    endcase
  endfunction

  logic                respValid;
  logic [ID_W-1:0]     respId;
  logic [31:0]         respImm;
  logic [ID_W-1:0]     rrPtr;

  logic                canIssue;
  logic                anyValid;
  logic                xfer;
  logic [NUM_REQ-1:0]  rotValid;
  logic [NUM_REQ-1:0]  blocked;
  logic [NUM_REQ-1:0]  firstHot;
  logic [ID_W-1:0]     offAcc [NUM_REQ];
  logic [ID_W-1:0]     offset;
  logic [ID_W:0]       ptrSum;
  logic [ID_W-1:0]     winId;
  logic [ID_W-1:0]     nextPtr;
  logic [31:0]         selInst;
  logic [2:0]          selSrc;
  logic                selSign;
  logic [31:0]         genImm;

  // A new result may enter when the register is empty or being drained, unless flushed.
  assign canIssue = !io_flush && (!respValid || io_resp_ready);
  assign anyValid = |io_req_valid;
  assign xfer     = canIssue && anyValid;

  // Rotate the valid vector so position 0 is the requester rrPtr points at.
  assign rotValid = NUM_REQ'({io_req_valid, io_req_valid} >> rrPtr);

  // Priority-encode the rotated vector: lowest set bit is the winner's offset.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_prio
    if (g == 0) begin : g_first
      assign blocked[g] = 1'b0;
      assign offAcc[g]  = '0;
    end else begin : g_rest
      assign blocked[g] = blocked[g-1] | rotValid[g-1];
      assign offAcc[g]  = offAcc[g-1] | (firstHot[g] ? ID_W'(g) : '0);
    end
    assign firstHot[g] = rotValid[g] & ~blocked[g];
    assign io_req_ready[g] = !reset && xfer && (winId == ID_W'(g));
  end
  assign offset = offAcc[NUM_REQ-1];

  // Map the rotated offset back to an absolute requester index, modulo NUM_REQ.
  assign ptrSum  = {1'b0, rrPtr} + {1'b0, offset};
  assign winId   = (ptrSum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(ptrSum - (ID_W+1)'(NUM_REQ))
                                                  : ptrSum[ID_W-1:0];
  assign nextPtr = (winId == ID_W'(NUM_REQ-1)) ? '0 : winId + 1'b1;

  // Steer the winner's fields into the shared generator.
  assign selInst = 32'(io_req_inst >> {winId, 5'd0});
  assign selSrc  = 3'(io_req_immSrc >> (3 * winId));
  assign selSign = 1'(io_req_immSign >> winId);
  assign genImm  = immGen(selInst, selSrc, selSign);

  // Result register and round-robin pointer; fill wins over drain, flush only clears valid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      respValid <= 1'b0;
      respId    <= '0;
      respImm   <= '0;
      rrPtr     <= '0;
    end else if (xfer) begin
      respValid <= 1'b1;
      respId    <= winId;
      respImm   <= genImm;
      rrPtr     <= nextPtr;
    end else if (io_flush || io_resp_ready) begin
      respValid <= 1'b0;
    end
  end

  assign io_resp_valid = respValid;
  assign io_resp_id    = respId;
  assign io_resp_imm   = respImm;

`ifdef IMM_GEN_ARBITER_STATS_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
    logic [15:0] grantCnt;
    // Count transfers for this requester, sticking at 0xFFFF.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        grantCnt <= '0;
      end else if (xfer && (winId == ID_W'(g)) && (grantCnt != 16'hFFFF)) begin
        grantCnt <= grantCnt + 16'd1;
      end
    end
    assign io_grant_cnt[16*g +: 16] = grantCnt;
  end
`endif

endmodule

// File: tb/tb_imm_gen_arbiter.sv
// Self-checking bench for imm_gen_arbiter: table of single-request immediate
// vectors, hand-written round-robin / backpressure / flush / reset sequences,
// and a randomized phase checked against a behavioural reference model.
module tb_imm_gen_arbiter;
  localparam int NUM_REQ = 2;
  localparam int ID_W    = 2;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  io_flush;
  logic [NUM_REQ-1:0]    io_req_valid;
  logic [NUM_REQ-1:0]    io_req_ready;
  logic [32*NUM_REQ-1:0] io_req_inst;
  logic [3*NUM_REQ-1:0]  io_req_immSrc;
  logic [NUM_REQ-1:0]    io_req_immSign;
  logic                  io_resp_valid;
  logic                  io_resp_ready;
  logic [ID_W-1:0]       io_resp_id;
  logic [31:0]           io_resp_imm;
`ifdef IMM_GEN_ARBITER_STATS_EN
  logic [16*NUM_REQ-1:0] io_grant_cnt;
`endif

  imm_gen_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .io_flush       (io_flush),
    .io_req_valid   (io_req_valid),
    .io_req_ready   (io_req_ready),
    .io_req_inst    (io_req_inst),
    .io_req_immSrc  (io_req_immSrc),
    .io_req_immSign (io_req_immSign),
    .io_resp_valid  (io_resp_valid),
    .io_resp_ready  (io_resp_ready),
    .io_resp_id     (io_resp_id),
    .io_resp_imm    (io_resp_imm)
`ifdef IMM_GEN_ARBITER_STATS_EN
    ,
    .io_grant_cnt   (io_grant_cnt)
`endif
  );

  // clock / reset block
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          m_valid;
  int          m_id;
  logic [31:0] m_imm;
  int          m_ptr;
  int          m_grants [NUM_REQ];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Immediate value from the ISA field layout, extended arithmetically.
  function automatic logic [31:0] ref_imm(input logic [31:0] inst, input logic [2:0] src,
                                          input logic sign);
    longint f;
    int     w;
    case (src)
      3'd1: begin f = {inst[31:25], inst[11:7]}; w = 12; end
      3'd2: begin f = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}; w = 13; end
      3'd3: return {inst[31:12], 12'h000};
      3'd4: begin f = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}; w = 21; end
      3'd5: return 32'(inst[19:15]);
      default: begin f = inst[31:20]; w = 12; end
    endcase
    if (sign && f >= (longint'(1) << (w - 1))) f = f - (longint'(1) << w);
    return 32'(f);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_id    = 0;
    m_imm   = '0;
    m_ptr   = 0;
    for (int k = 0; k < NUM_REQ; k++) m_grants[k] = 0;
  endtask

  task automatic set_req(input int k, input logic [31:0] inst, input logic [2:0] src,
                         input logic sign);
    io_req_inst[32*k +: 32] = inst;
    io_req_immSrc[3*k +: 3] = src;
    io_req_immSign[k]       = sign;
  endtask

  // One clock: check DUT against the model at negedge, advance the model, return at posedge+1.
  task automatic model_cycle();
    bit               can_issue;
    int               win;
    logic [NUM_REQ-1:0] exp_ready;
    @(negedge clock);
    can_issue = !io_flush && (!m_valid || io_resp_ready);
    win = -1;
    for (int i = 0; i < NUM_REQ; i++) begin
      int k;
      k = (m_ptr + i) % NUM_REQ;
      if (win < 0 && io_req_valid[k]) win = k;
    end
    exp_ready = '0;
    if (can_issue && win >= 0) exp_ready[win] = 1'b1;
    chk("req_ready", 32'(io_req_ready), 32'(exp_ready));
    chk("resp_valid", 32'(io_resp_valid), 32'(m_valid));
    if (m_valid) begin
      chk("resp_id", 32'(io_resp_id), 32'(m_id));
      chk("resp_imm", io_resp_imm, m_imm);
    end
`ifdef IMM_GEN_ARBITER_STATS_EN
    for (int k = 0; k < NUM_REQ; k++)
      chk("grant_cnt", 32'(io_grant_cnt[16*k +: 16]), 32'(m_grants[k]));
`endif
    if (can_issue && win >= 0) begin
      m_valid = 1'b1;
      m_id    = win;
      m_imm   = ref_imm(io_req_inst[32*win +: 32], io_req_immSrc[3*win +: 3], io_req_immSign[win]);
      m_ptr   = (win + 1) % NUM_REQ;
      m_grants[win]++;
    end else if (io_flush || io_resp_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    int          req;
    logic [31:0] inst;
    logic [2:0]  src;
    logic        sign;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [14];

  initial begin
    vecs[0]  = '{0, 32'hFFF00093, 3'd0, 1'b1, 32'hFFFFFFFF};
    vecs[1]  = '{0, 32'hFFF00093, 3'd0, 1'b0, 32'h00000FFF};
    vecs[2]  = '{1, 32'h00000463, 3'd2, 1'b1, 32'h00000008};
    vecs[3]  = '{1, 32'hFE000EE3, 3'd2, 1'b1, 32'hFFFFFFFC};
    vecs[4]  = '{0, 32'h0007D073, 3'd5, 1'b1, 32'h0000000F};
    vecs[5]  = '{1, 32'hFE112E23, 3'd1, 1'b1, 32'hFFFFFFFC};
    vecs[6]  = '{0, 32'hFE112E23, 3'd1, 1'b0, 32'h00000FFC};
    vecs[7]  = '{1, 32'h12345037, 3'd3, 1'b1, 32'h12345000};
    vecs[8]  = '{0, 32'h80000037, 3'd3, 1'b0, 32'h80000000};
    vecs[9]  = '{1, 32'h0080006F, 3'd4, 1'b1, 32'h00000008};
    vecs[10] = '{0, 32'hFFF00093, 3'd7, 1'b1, 32'hFFFFFFFF};
    vecs[11] = '{1, 32'hFE000EE3, 3'd2, 1'b0, 32'h00001FFC};
    vecs[12] = '{0, 32'hFFDFF06F, 3'd4, 1'b0, 32'h001FFFFC};
    vecs[13] = '{1, 32'hFFDFF06F, 3'd4, 1'b1, 32'hFFFFFFFC};

    reset          = 1'b1;
    io_flush       = 1'b0;
    io_req_valid   = '0;
    io_req_inst    = '0;
    io_req_immSrc  = '0;
    io_req_immSign = '0;
    io_resp_ready  = 1'b1;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    io_req_valid = '1;
    #1;
    chk("reset_ready", 32'(io_req_ready), 32'h0);
    chk("reset_valid", 32'(io_resp_valid), 32'h0);
    chk("reset_id", 32'(io_resp_id), 32'h0);
    chk("reset_imm", io_resp_imm, 32'h0);
    io_req_valid = '0;
    reset = 1'b0;

    // table-driven single requests
    for (int v = 0; v < 14; v++) begin
      io_req_valid = '0;
      io_req_valid[vecs[v].req] = 1'b1;
      set_req(vecs[v].req, vecs[v].inst, vecs[v].src, vecs[v].sign);
      #1;
      chk("vec_ready", 32'(io_req_ready), 32'(1 << vecs[v].req));
      model_cycle();
      io_req_valid = '0;
      #1;
      chk("vec_valid", 32'(io_resp_valid), 32'h1);
      chk("vec_id", 32'(io_resp_id), 32'(vecs[v].req));
      chk("vec_imm", io_resp_imm, vecs[v].exp);
      model_cycle();
    end

    // round robin with both requesters always valid
    set_req(0, 32'hFFF00093, 3'd0, 1'b1);
    set_req(1, 32'h00000463, 3'd2, 1'b1);
    io_req_valid  = 2'b11;
    io_resp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("rr_ready", 32'(io_req_ready), (c % 2 == 0) ? 32'h1 : 32'h2);
      if (c > 0) begin
        chk("rr_valid", 32'(io_resp_valid), 32'h1);
        chk("rr_id", 32'(io_resp_id), 32'((c - 1) % 2));
      end
      model_cycle();
    end

    // backpressure: result held stable, no grants
    io_resp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_ready", 32'(io_req_ready), 32'h0);
      chk("bp_valid", 32'(io_resp_valid), 32'h1);
      chk("bp_id", 32'(io_resp_id), 32'h1);
      chk("bp_imm", io_resp_imm, 32'h00000008);
      model_cycle();
    end
    io_resp_ready = 1'b1;
    #1;
    chk("bp_drain_ready", 32'(io_req_ready), 32'h1);
    model_cycle();
    #1;
    chk("bp_fill_valid", 32'(io_resp_valid), 32'h1);
    chk("bp_fill_id", 32'(io_resp_id), 32'h0);
    chk("bp_fill_imm", io_resp_imm, 32'hFFFFFFFF);

    // flush: kills held result, no grant, pointer kept
    io_flush = 1'b1;
    #1;
    chk("fl_ready", 32'(io_req_ready), 32'h0);
    model_cycle();
    io_flush = 1'b0;
    #1;
    chk("fl_valid", 32'(io_resp_valid), 32'h0);
    chk("fl_ptr_ready", 32'(io_req_ready), 32'h2);
    model_cycle();
    #1;
    chk("fl_id", 32'(io_resp_id), 32'h1);
    chk("fl_imm", io_resp_imm, 32'h00000008);
    model_cycle();

    // asynchronous reset mid-stream
    #1;
    reset = 1'b1;
    #1;
    chk("rst_valid", 32'(io_resp_valid), 32'h0);
    chk("rst_ready", 32'(io_req_ready), 32'h0);
    chk("rst_id", 32'(io_resp_id), 32'h0);
    chk("rst_imm", io_resp_imm, 32'h0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_first_ready", 32'(io_req_ready), 32'h1);
    model_cycle();
    #1;
    chk("rst_first_valid", 32'(io_resp_valid), 32'h1);
    chk("rst_first_id", 32'(io_resp_id), 32'h0);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      io_req_valid  = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
      io_resp_ready = ($urandom_range(0, 3) != 0);
      io_flush      = ($urandom_range(0, 9) == 0);
      for (int k = 0; k < NUM_REQ; k++)
        set_req(k, $urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      model_cycle();
    end
    io_flush = 1'b0;

`ifdef IMM_GEN_ARBITER_STATS_EN
    // saturation of requester 0's counter
    io_req_valid  = 2'b01;
    io_resp_ready = 1'b1;
    repeat (65540) @(posedge clock);
    #1;
    io_req_valid = '0;
    #1;
    chk("sat_cnt0", 32'(io_grant_cnt[15:0]), 32'h0000FFFF);
    chk("sat_cnt1", 32'(io_grant_cnt[31:16]), 32'(m_grants[1]));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
